fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the PSRV32 pipeline. It sits directly upstream of the control/decode block and drives that block's instruction input.
- Holds the PC and issues in-order requests to instruction memory over a req/gnt/rvalid interface.
- Buffers returned words in a small FIFO and presents {pc, instruction} with a valid flag to decode.
- Handles decode back-pressure (stall) and branch/jump redirects, discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, max outstanding requests plus buffered instructions; also the FIFO depth; must be >= 2.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch address, word aligned.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response data valid; responses return in order, at least 1 cycle after grant.
- imem_rdata_i  in  32  response instruction word.
- redirect_i  in  1  branch/jump taken; restart fetch.
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored (forced 0).
- stall_i  in  1  decode cannot accept this cycle.
- instr_valid_o  out  1  instruction_o/pc_o valid.
- instruction_o  out  32  instruction to decode.
- pc_o  out  32  address of instruction_o.

Behaviour:
- Reset state (async assert): pc = RESET_PC, out_cnt = 0, drop_cnt = 0, FIFO empty, address queue empty. Outputs: imem_req_o = 0, instr_valid_o = 0, instruction_o = 32'h0000_0013 (NOP), pc_o = 0.
- pop = instr_valid_o & ~stall_i.
- imem_req_o = ~redirect_i & (out_cnt + fifo_cnt - pop < DEPTH). imem_addr_o = pc.
- Handshake: the address is held stable while imem_req_o=1 and imem_gnt_i=0. A grant is only valid while imem_req_o=1.
- On req & gnt: pc <= pc + 4 (wraps modulo 2^32), out_cnt++, and the address is pushed to the address queue (depth DEPTH).
- On rvalid: out_cnt--, address queue pops.
  - If drop_cnt > 0: drop_cnt--, data discarded.
  - Otherwise {queue head, imem_rdata_i} is pushed into the FIFO.
  - rvalid with out_cnt = 0 is a protocol error: ignored and flagged by a bench assertion.
- Output: instr_valid_o = FIFO non-empty; instruction_o/pc_o = FIFO head, else NOP/0. The head is held unchanged while stall_i=1.
- Latency: response at cycle N -> instr_valid_o at N+1. With zero-wait grant, 1-cycle response and no stall, throughput is 1 instruction/cycle.
- Redirect (cycle R):
  - No request issued in R.
  - pc <= {redirect_pc_i[31:2], 2'b00}; FIFO cleared; instr_valid_o = 0 at R+1.
  - drop_cnt <= out_cnt after this cycle's grant/rvalid updates, so all in-flight responses are discarded.
  - A response arriving in cycle R is discarded.
  - Fetching resumes at R+1 once out_cnt + fifo_cnt < DEPTH.
  - Redirect overrides stall_i.
  - Back-to-back redirects: the last target wins; drop_cnt is recomputed each time.
- Simultaneous push and pop in a cycle: FIFO count unchanged, no overflow. The credit rule guarantees the FIFO never overflows.
- Reset asserted mid-operation clears everything. In-flight responses arriving after reset deasserts are the memory model's responsibility; the memory must also be reset.

Decomposition:
- Shared package psrv32_pkg holds:
  - XLEN = 32; NOP_INSTR = 32'h0000_0013; default RESET_PC.
  - Opcode localparams (RXX, IXX, BXX, LUI, AUIPC, JAL, JALR, LXX, SXX), shared with control.
- Sub-module fetch_fifo:
  - Parameterised synchronous FIFO of {pc, instr} entries.
  - Ports for push, pop, flush, count, head.
  - Asynchronous active-high reset on rst_i.
  - Also instantiated with width 32 for the address queue.

Test Plan:
- Reset release, memory grants immediately, 1-cycle response, stall_i=0 -> requests at 0x0, 0x4, 0x8 on consecutive cycles; instr_valid_o high from cycle 2; pc_o sequence 0x0, 0x4, 0x8 with matching data.
- stall_i held 5 cycles during streaming -> at most DEPTH=2 outstanding plus buffered, imem_req_o drops, no instruction lost or duplicated; on release the stream continues at the next pc.
- imem_gnt_i withheld 3 cycles -> imem_addr_o held at 0x10 throughout, pc advances only after the grant.
- Two requests in flight (0x20, 0x24), redirect_i to 0x100 -> both responses dropped, instr_valid_o=0 next cycle, next valid output has pc_o=0x100.
- Redirect in the same cycle as rvalid, with redirect_pc_i=0x203 -> response discarded, next fetch address 0x200.
- rst_i asserted mid-stream with a non-empty FIFO -> outputs return to reset values asynchronously; after release, first request is at RESET_PC.

Source files
------------

// File: rtl/psrv32_pkg.sv
// Shared PSRV32 definitions: machine width, canonical NOP, reset vector,
// base opcodes and the fetch-to-decode entry layout.
package psrv32_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] RXX   = 7'b0110011;
  localparam logic [6:0] IXX   = 7'b0010011;
  localparam logic [6:0] BXX   = 7'b1100011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LXX   = 7'b0000011;
  localparam logic [6:0] SXX   = 7'b0100011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; holds fetched {pc, instr} entries and
// doubles as the in-flight address queue.
module fetch_fifo #(
  parameter int  WIDTH = 64,
  parameter int  DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    // a full FIFO still accepts a write when the head leaves in the same cycle
    do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop)  rd_d = ptr_inc(rd_q);
      if (do_push) wr_d = ptr_inc(wr_q);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_stage.sv
// PSRV32 instruction fetch: PC, credit-limited in-order imem requests,
// response buffering and redirect handling with stale-response dropping.
module fetch_stage
  import psrv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            stall_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instruction_o,
  output logic [XLEN-1:0] pc_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] out_cnt, out_cnt_after, fifo_cnt;
  logic [SUM_W-1:0] occupancy;
  logic             pop, grant, rsp_ok, rsp_keep;
  logic [XLEN-1:0]  aq_head;
  fetch_entry_t     fifo_head, fifo_wdata;

  // Credit: in-flight requests plus buffered entries never exceed DEPTH,
  // which is what keeps the instruction FIFO from overflowing.
  assign pop        = instr_valid_o & ~stall_i;
  assign occupancy  = SUM_W'(out_cnt) + SUM_W'(fifo_cnt) - SUM_W'(pop);
  assign imem_req_o = ~rst_i & ~redirect_i & (occupancy < SUM_W'(DEPTH));
  assign imem_addr_o = pc_q;
  assign grant      = imem_req_o & imem_gnt_i;
  assign rsp_ok     = imem_rvalid_i & (out_cnt != '0);
  assign rsp_keep   = rsp_ok & (drop_q == '0) & ~redirect_i;
  assign fifo_wdata = {aq_head, imem_rdata_i};

  always_comb begin
    out_cnt_after = out_cnt + CNT_W'(grant) - CNT_W'(rsp_ok);
    pc_d          = pc_q;
    drop_d        = drop_q;
    if (grant) pc_d = pc_q + XLEN'(4);
    if (rsp_ok && (drop_q != '0)) drop_d = drop_q - 1'b1;
    if (redirect_i) begin
      pc_d   = align_word(redirect_pc_i);
      drop_d = out_cnt_after;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  // Address queue: its occupancy is the outstanding-request count.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_q (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (grant),
    .wdata_i (pc_q),
    .pop_i   (rsp_ok),
    .flush_i (1'b0),
    .count_o (out_cnt),
    .head_o  (aq_head)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_q (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rsp_keep),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .count_o (fifo_cnt),
    .head_o  (fifo_head)
  );

  assign instr_valid_o = (fifo_cnt != '0);
  assign instruction_o = instr_valid_o ? fifo_head.instr : NOP_INSTR;
  assign pc_o          = instr_valid_o ? fifo_head.pc : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: an in-order memory responder plus an
// epoch-tagged reference of the instruction stream decode should see.
module tb_fetch_stage;
  import psrv32_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        redirect_i, stall_i, instr_valid_o;
  logic [31:0] redirect_pc_i, instruction_o, pc_o;

  fetch_stage #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .instr_valid_o (instr_valid_o),
    .instruction_o (instruction_o),
    .pc_o          (pc_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int ep; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } out_t;

  req_t        memq[$];   // granted requests awaiting a response
  out_t        expq[$];   // instructions decode should receive, in order
  int          total = 0, bad = 0;
  int          epoch = 0;
  logic [31:0] exp_addr = RST_PC;
  bit          prev_redir = 1'b0;
  int          p_gnt = 100, p_rv = 100, p_stall = 0, p_redir = 0;
  bit          force_redir = 1'b0;
  logic [31:0] force_tgt = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] rand_target();
    case ($urandom_range(3))
      0:       return 32'hFFFF_FFF0 | ($urandom & 32'hF);
      1:       return $urandom;
      default: return $urandom & 32'h0000_0FFF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_idle();
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0;
    redirect_i = 0; redirect_pc_i = '0; stall_i = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    #1;
    check("rst_req",   imem_req_o,    0);
    check("rst_valid", instr_valid_o, 0);
    check("rst_instr", instruction_o, NOP_INSTR);
    check("rst_pc",    pc_o,          0);
    memq.delete(); expq.delete();
    epoch = 0; exp_addr = RST_PC; prev_redir = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cycle();
    bit   pop_m, req_m;
    req_t r;
    out_t o;
    @(negedge clk);
    imem_gnt_i    = ($urandom_range(99) < p_gnt);
    imem_rvalid_i = (memq.size() > 0) && ($urandom_range(99) < p_rv);
    imem_rdata_i  = imem_rvalid_i ? mem_word(memq[0].addr) : $urandom;
    stall_i       = ($urandom_range(99) < p_stall);
    redirect_i    = force_redir || ($urandom_range(99) < p_redir);
    redirect_pc_i = force_redir ? force_tgt : rand_target();
    assert (!imem_rvalid_i || memq.size() > 0) else $error("rvalid with nothing outstanding");
    #1;
    pop_m = (expq.size() > 0) && !stall_i;
    req_m = !redirect_i && (memq.size() + expq.size() - int'(pop_m) < DEPTH);
    check("req",   imem_req_o,    req_m);
    check("valid", instr_valid_o, expq.size() > 0);
    if (prev_redir) check("valid_after_redir", instr_valid_o, 0);
    if (expq.size() > 0) begin
      check("pc",    pc_o,          expq[0].pc);
      check("instr", instruction_o, expq[0].ins);
    end else begin
      check("idle_pc",    pc_o,          0);
      check("idle_instr", instruction_o, NOP_INSTR);
    end
    check("addr", imem_addr_o, exp_addr);
    if (pop_m && !redirect_i) expq.delete(0);
    if (imem_rvalid_i) begin
      r = memq.pop_front();
      if (!redirect_i && r.ep == epoch) begin
        o.pc = r.addr; o.ins = mem_word(r.addr);
        expq.push_back(o);
      end
    end
    if (imem_req_o && imem_gnt_i) begin
      r.addr = imem_addr_o; r.ep = epoch;
      memq.push_back(r);
      exp_addr = imem_addr_o + 32'd4;
    end
    if (redirect_i) begin
      expq.delete();
      epoch++;
      exp_addr = redirect_pc_i & ~32'h3;
    end
    prev_redir = redirect_i;
  endtask

  initial begin
    int n;
    drive_idle();
    #2;
    do_reset();

    // zero-wait streaming: first valid two cycles after the first request
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("first_valid", instr_valid_o, 32'(i == 2));
    end
    repeat (20) cycle();

    // decode stall, then grant withheld
    p_stall = 100; repeat (5) cycle();
    p_stall = 0;   repeat (10) cycle();
    p_gnt = 0;     repeat (3) cycle();
    p_gnt = 100;   repeat (6) cycle();

    // two requests in flight, then redirect to 0x100
    p_rv = 0; repeat (3) cycle();
    force_redir = 1; force_tgt = 32'h100; cycle();
    force_redir = 0; p_rv = 100; cycle();
    n = 0;
    while (!instr_valid_o && n < 20) begin cycle(); n++; end
    check("redir_first_pc", pc_o, 32'h100);

    // redirect coinciding with a response, unaligned target
    repeat (4) cycle();
    force_redir = 1; force_tgt = 32'h203; cycle();
    force_redir = 0; cycle();
    check("redir_aligned_addr", imem_addr_o, 32'h200);

    // randomized traffic
    p_gnt = 70; p_rv = 60; p_stall = 30; p_redir = 3;
    repeat (3000) cycle();
    p_gnt = 30; p_rv = 90; p_stall = 10; p_redir = 5;
    repeat (2000) cycle();

    // asynchronous reset with a full instruction buffer
    p_gnt = 100; p_rv = 100; p_stall = 100; p_redir = 0;
    repeat (5) cycle();
    check("pre_rst_valid", instr_valid_o, 1);
    #2;
    do_reset();
    p_stall = 0;
    cycle();
    check("post_rst_addr", imem_addr_o, RST_PC);
    check("post_rst_req",  imem_req_o,  1);
    repeat (10) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
